// File: rtl/rag_csd_sim_pkg.sv
// Shared types for the similarity pair feeder.
//   metric_t       : similarity metric selector driven to the compute block
//   feeder_state_t : command-level control states
//   res_t          : default tagged result entry {id, last, score}
package rag_csd_sim_pkg;

  typedef enum logic [1:0] {
    COSINE = 2'd0,
    DOT    = 2'd1,
    EUCLID = 2'd2
  } metric_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } feeder_state_t;

  localparam int unsigned RES_ID_W = 16;

  typedef struct packed {
    logic [RES_ID_W-1:0] id;
    logic                last;
    logic [31:0]         score;
  } res_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_result_fifo.sv
// Show-ahead synchronous FIFO for tagged similarity results.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless popping)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, valid while count != 0
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two; pointers wrap naturally.
module sim_result_fifo
  import rag_csd_sim_pkg::*;
#(
  parameter type         entry_t = res_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/similarity_pair_feeder.sv
// Initiator for a pipelined similarity-compute block.
// Streams document embeddings from word-addressed memory into two ping-pong
// buffers, starts one comparison at a time against the latched query, and
// queues tagged scores {id, score, last} for the top-k stage.
//   cmd_*       : command handshake, base address, first id, count, metric
//   query_vec   : query embedding, latched on command accept
//   mem_rd_*    : in-order read port (req/gnt, valid/data)
//   sim_*       : start/metric/vectors out, done/similarity back
//   res_*       : show-ahead result stream with valid/ready
//   busy, cmd_done, err : status; err is sticky until the next accept
module similarity_pair_feeder
  import rag_csd_sim_pkg::*;
#(
  parameter int unsigned EMBEDDING_DIM = 384,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned ID_W          = 16,
  parameter int unsigned RES_DEPTH     = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_W-1:0]          cmd_base_addr,
  input  logic [ID_W-1:0]            cmd_first_id,
  input  logic [ID_W-1:0]            cmd_count,
  input  logic [1:0]                 cmd_metric,
  input  logic [EMBEDDING_DIM*32-1:0] query_vec,
  output logic                       mem_rd_req,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic                       mem_rd_gnt,
  input  logic                       mem_rd_valid,
  input  logic [31:0]                mem_rd_data,
  output logic                       sim_start,
  output logic [1:0]                 sim_metric,
  output logic [EMBEDDING_DIM*32-1:0] sim_vec_a,
  output logic [EMBEDDING_DIM*32-1:0] sim_vec_b,
  input  logic                       sim_done,
  input  logic [31:0]                sim_similarity,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [31:0]                res_score,
  output logic                       res_last,
  output logic                       busy,
  output logic                       cmd_done,
  output logic                       err
);

  localparam int unsigned EW = cnt_w(EMBEDDING_DIM);
  localparam int unsigned OW = EW + 2;
  localparam int unsigned WW = cnt_w(TIMEOUT) + 1;
  localparam int unsigned FW = $clog2(RES_DEPTH) + 1;
  localparam logic [EW-1:0] LAST_ELEM = EW'(EMBEDDING_DIM - 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
    logic [31:0]     score;
  } entry_t;

  typedef logic [EMBEDDING_DIM-1:0][31:0] vec_t;

  feeder_state_t               state, state_next;
  logic [ADDR_W-1:0]           base;
  logic [ID_W-1:0]             first_id, count;
  logic [ID_W-1:0]             req_doc, ret_doc, done_doc;
  metric_t                     metric;
  logic [EMBEDDING_DIM*32-1:0] query;
  logic [EW-1:0]               req_elem, ret_elem;
  logic                        req_sel, ret_sel, iss_sel, cur_sel;
  logic [1:0]                  buf_alloc, buf_full, buf_last;
  logic [ID_W-1:0]             buf_id [2];
  vec_t                        buf_data [2];
  logic [OW-1:0]               outstanding;
  logic                        in_flight, start_q, err_q;
  logic [ID_W-1:0]             cur_id;
  logic                        cur_last;
  logic [WW-1:0]               wd;
  entry_t                      push_data, head;
  logic [FW-1:0]               fifo_count;
  logic accept, req, gnt_fire, ret_fire, stray_ret, issue, timeout, complete, pop;

  assign accept    = cmd_valid && (state == IDLE);
  // A buffer is claimed on its first granted request and released only when
  // its comparison completes, so the buffer under comparison is never refilled.
  assign req       = (state == RUN) && (req_doc < count) &&
                     ((req_elem != '0) || !buf_alloc[req_sel]);
  assign gnt_fire  = req && mem_rd_gnt;
  assign ret_fire  = mem_rd_valid && (outstanding != '0);
  assign stray_ret = mem_rd_valid && (outstanding == '0);
  assign issue     = (state == RUN) && buf_full[iss_sel] && !in_flight &&
                     (fifo_count < FW'(RES_DEPTH));
  assign timeout   = in_flight && !sim_done && (wd == WW'(TIMEOUT - 1));
  assign complete  = in_flight && (sim_done || timeout);
  assign pop       = res_valid && res_ready;

  assign mem_rd_req  = req;
  assign mem_rd_addr = req ? base + ADDR_W'(req_doc) * ADDR_W'(EMBEDDING_DIM) + ADDR_W'(req_elem)
                           : '0;
  assign sim_start   = start_q;
  assign sim_metric  = metric;
  assign sim_vec_a   = query;
  assign sim_vec_b   = in_flight ? buf_data[cur_sel] : '0;
  assign err         = err_q;
  assign res_valid   = (fifo_count != '0);
  assign res_id      = head.id;
  assign res_last    = head.last;
  assign res_score   = head.score;
  assign push_data   = '{id: cur_id, last: cur_last, score: sim_done ? sim_similarity : 32'h0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    cmd_done   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = (cmd_count == '0) ? FINISH : RUN;
      end
      RUN:    if (done_doc == count && fifo_count == '0) state_next = FINISH;
      FINISH: begin
        cmd_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base        <= '0;
      first_id    <= '0;
      count       <= '0;
      metric      <= COSINE;
      query       <= '0;
      req_doc     <= '0;
      ret_doc     <= '0;
      done_doc    <= '0;
      req_elem    <= '0;
      ret_elem    <= '0;
      req_sel     <= 1'b0;
      ret_sel     <= 1'b0;
      iss_sel     <= 1'b0;
      cur_sel     <= 1'b0;
      buf_alloc   <= '0;
      buf_full    <= '0;
      buf_last    <= '0;
      buf_id[0]   <= '0;
      buf_id[1]   <= '0;
      outstanding <= '0;
      in_flight   <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      cur_id      <= '0;
      cur_last    <= 1'b0;
      wd          <= '0;
    end else begin
      start_q     <= 1'b0;
      outstanding <= outstanding + OW'(gnt_fire) - OW'(ret_fire);
      if (stray_ret || (sim_done && !in_flight) || timeout) err_q <= 1'b1;

      if (accept) begin
        base      <= cmd_base_addr;
        first_id  <= cmd_first_id;
        count     <= cmd_count;
        metric    <= metric_t'(cmd_metric);
        query     <= query_vec;
        err_q     <= 1'b0;
        req_doc   <= '0;
        ret_doc   <= '0;
        done_doc  <= '0;
        req_elem  <= '0;
        ret_elem  <= '0;
        req_sel   <= 1'b0;
        ret_sel   <= 1'b0;
        iss_sel   <= 1'b0;
        buf_alloc <= '0;
        buf_full  <= '0;
      end

      if (gnt_fire) begin
        if (req_elem == '0) buf_alloc[req_sel] <= 1'b1;
        if (req_elem == LAST_ELEM) begin
          req_elem <= '0;
          req_doc  <= req_doc + ID_W'(1);
          req_sel  <= ~req_sel;
        end else begin
          req_elem <= req_elem + EW'(1);
        end
      end

      // Returns arrive in request order, so the fill side walks the same
      // ping-pong sequence as the request side, just later.
      if (ret_fire) begin
        if (ret_elem == LAST_ELEM) begin
          ret_elem          <= '0;
          buf_full[ret_sel] <= 1'b1;
          buf_id[ret_sel]   <= first_id + ret_doc;
          buf_last[ret_sel] <= (ret_doc == count - ID_W'(1));
          ret_doc           <= ret_doc + ID_W'(1);
          ret_sel           <= ~ret_sel;
        end else begin
          ret_elem <= ret_elem + EW'(1);
        end
      end

      if (issue) begin
        start_q   <= 1'b1;
        in_flight <= 1'b1;
        cur_sel   <= iss_sel;
        cur_id    <= buf_id[iss_sel];
        cur_last  <= buf_last[iss_sel];
        iss_sel   <= ~iss_sel;
        wd        <= '0;
      end else if (in_flight) begin
        wd <= wd + WW'(1);
      end

      if (complete) begin
        in_flight          <= 1'b0;
        buf_full[cur_sel]  <= 1'b0;
        buf_alloc[cur_sel] <= 1'b0;
        done_doc           <= done_doc + ID_W'(1);
      end
    end
  end

  // Vector storage carries no reset; sim_vec_b is gated by in_flight instead.
  always_ff @(posedge clk) begin
    if (ret_fire) buf_data[ret_sel][ret_elem] <= mem_rd_data;
  end

  sim_result_fifo #(
    .entry_t (entry_t),
    .DEPTH   (RES_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (complete),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule
